approx_error_monitor: RTL
=========================

Name: approx_error_monitor

Overview:
- Streaming checker: the consumer end of the approximate-adder test stimulus path.
- Accepts operand pairs plus an approximate adder's result {fn, sum}, computes the exact sum internally, and accumulates error statistics over a programmable window.
- Statistics: sample count, erroneous-sample count, summed error distance, maximum error distance.
- Used in simulation and on-FPGA characterisation of the nBitRcpa-family adders.

Parameters:
- N, 8: operand/sum width of the adder under test.
- CNT_W, 16: width of the window length and sample/error counters.
- ACC_W, 32: width of the summed-error-distance accumulator (must be >= N+1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears statistics and begins a window.
- win_len  in  CNT_W  number of samples in the window; sampled on an accepted start.
- in_valid  in  1  sample present.
- in_ready  out  1  monitor accepts a sample this cycle.
- a, b  in  N  operands applied to the adder.
- sum_apx  in  N  approximate sum.
- fn_apx  in  1  approximate carry-out.
- busy  out  1  window in progress (RUN or DRAIN).
- done  out  1  window complete; statistics final.
- n_samples  out  CNT_W  samples accepted.
- n_err  out  CNT_W  samples with nonzero error distance.
- sum_ed  out  ACC_W  saturating sum of error distances.
- max_ed  out  N+1  largest error distance.
- ovf  out  1  sticky; sum_ed saturated.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output is 0, including in_ready, busy, done and all statistics.
- Exact sum = a + b, N+1 bits. Approx = {fn_apx, sum_apx}, N+1 bits.
- ED = |approx - exact|, unsigned N+1 bits. A sample is erroneous iff ED != 0.
- States:
  - IDLE: in_ready=0. On start: clear all statistics and ovf, latch win_len. Go to RUN, or to DONE if win_len==0.
  - RUN: in_ready=1 while accepted count < latched win_len. A sample is accepted when in_valid && in_ready. When the final sample is accepted, in_ready drops in the next cycle and the state goes to DRAIN.
  - DRAIN: wait for the pipeline to empty, then go to DONE.
  - DONE: done=1, statistics held stable. start: clear and restart as from IDLE.
- Pipeline:
  - Stage 1 registers exact and approx.
  - Stage 2 computes ED and updates n_samples, n_err, sum_ed, max_ed.
  - Statistics for a sample accepted at edge k are visible after edge k+2.
  - done rises after edge k+2, where k is the final accepted sample's edge.
- busy=1 in RUN and DRAIN.
- start in RUN or DRAIN is ignored.
- in_valid while in_ready=0 is ignored, with no backpressure error. Gaps in in_valid are allowed.
- sum_ed saturates at 2^ACC_W-1. ovf is set and stays set until the next start.
- n_samples cannot wrap, since win_len < 2^CNT_W.
- max_ed updates with a strict greater-than compare.
- rst_n asserted mid-window: immediate return to IDLE with all outputs 0. Partial results are discarded.

Optional Feature:
- Macro: APPROX_MON_SQ_EN.
- Defined: adds output sum_sq_ed, width 2*(N+1)+CNT_W, accumulating ED*ED at stage 2. It is wide enough never to overflow, cleared on start, zero at reset.
- Undefined: the port and the squarer are absent. All other behaviour is identical.

Decomposition:
- Package approx_mon_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - localparam helpers for ED width (N+1) and squared-accumulator width.
- One combinational sub-module, approx_err_dist: inputs a, b, sum_apx, fn_apx; outputs exact, ED, is_err.

Test Plan:
- Exact stream, win_len=4, four samples with {fn,sum}=a+b (0x32+0x01 -> 0x033, etc.):
  - n_samples=4, n_err=0, sum_ed=0, max_ed=0.
  - done 2 edges after the 4th accept; in_ready low after the 4th accept.
- win_len=2, two erroneous samples:
  - a=0x51, b=0x12, apx=0x060 -> ED=3.
  - a=0x3C, b=0x51, apx=0x08F -> ED=2.
  - Expect n_err=2, sum_ed=5, max_ed=3.
- Carry case: a=0xFF, b=0x01, apx {0,0x00} -> ED=0x100, max_ed=256, n_err=1.
- Saturation with ACC_W=9, win_len=2, both samples ED=256 -> sum_ed=511, ovf=1. A new start clears ovf to 0.
- Control boundaries:
  - win_len=0 -> done one cycle after start, with zero stats.
  - in_valid gaps of 3 cycles -> same results as back-to-back.
  - start mid-RUN -> no effect.
- rst_n pulsed low after 2 of 4 samples -> all outputs 0, IDLE. A subsequent start runs a clean window.

Source files
------------

// File: rtl/approx_mon_pkg.sv
// approx_mon_pkg: shared state encoding and width helpers for the approximate-adder error monitor.
package approx_mon_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mon_state_t;
    function automatic int ed_w(input int n);
        return n + 1;
    endfunction
    function automatic int sq_w(input int n, input int cnt_w);
        return 2 * (n + 1) + cnt_w;
    endfunction
endpackage

// File: rtl/approx_err_dist.sv
// approx_err_dist: exact sum and error distance of an approximate adder result {fn, sum}.
module approx_err_dist
    import approx_mon_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]       a,
    input  logic [N-1:0]       b,
    input  logic [N-1:0]       sum_apx,
    input  logic               fn_apx,
    output logic [ed_w(N)-1:0] exact,
    output logic [ed_w(N)-1:0] ed,
    output logic               is_err
);
    logic [ed_w(N)-1:0] apx;
    always_comb begin
        exact  = {1'b0, a} + {1'b0, b};
        apx    = {fn_apx, sum_apx};
        ed     = apx >= exact ? apx - exact : exact - apx;
        is_err = ed != '0;
    end
endmodule

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: windowed error statistics for an approximate adder under test.
// Defining APPROX_MON_SQ_EN adds the sum_sq_ed output (sum of squared error distances).
module approx_error_monitor
    import approx_mon_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     sum_apx,
    input  logic             fn_apx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] n_samples,
    output logic [CNT_W-1:0] n_err,
    output logic [ACC_W-1:0] sum_ed,
    output logic [N:0]       max_ed,
    output logic             ovf
`ifdef APPROX_MON_SQ_EN
    ,
    output logic [sq_w(N, CNT_W)-1:0] sum_sq_ed
`endif
);
    localparam int EW = ed_w(N);
    mon_state_t       st;
    logic [CNT_W-1:0] len, cnt, cnt_nx;
    logic [EW-1:0]    exact, ed, d1, d2;
    logic             is_err, e1, e2, v1, v2, acc, go, unused_exact;
    logic [ACC_W:0]   ed_sum;

    approx_err_dist #(.N(N)) u_dist (
        .a(a), .b(b), .sum_apx(sum_apx), .fn_apx(fn_apx),
        .exact(exact), .ed(ed), .is_err(is_err)
    );

    assign acc          = in_valid && in_ready;
    assign go           = start && (st == IDLE || st == DONE);
    assign cnt_nx       = cnt + 1'b1;
    assign ed_sum       = {1'b0, sum_ed} + (ACC_W + 1)'(d2);
    assign busy         = st == RUN || st == DRAIN;
    assign done         = st == DONE;
    assign unused_exact = ^exact;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            len       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            e1        <= 1'b0;
            e2        <= 1'b0;
            d1        <= '0;
            d2        <= '0;
            n_samples <= '0;
            n_err     <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            ovf       <= 1'b0;
        end else begin
            v1 <= acc;
            e1 <= is_err;
            d1 <= ed;
            v2 <= v1;
            e2 <= e1;
            d2 <= d1;
            if (go) begin
                len       <= win_len;
                cnt       <= '0;
                in_ready  <= win_len != '0;
                st        <= win_len == '0 ? DONE : RUN;
                n_samples <= '0;
                n_err     <= '0;
                sum_ed    <= '0;
                max_ed    <= '0;
                ovf       <= 1'b0;
            end else begin
                if (v2) begin
                    n_samples <= n_samples + 1'b1;
                    n_err     <= n_err + CNT_W'(e2);
                    sum_ed    <= ed_sum[ACC_W] ? '1 : ed_sum[ACC_W-1:0];
                    ovf       <= ovf | ed_sum[ACC_W];
                    if (d2 > max_ed) max_ed <= d2;
                end
                if (st == RUN && acc) begin
                    cnt <= cnt_nx;
                    if (cnt_nx == len) begin
                        in_ready <= 1'b0;
                        st       <= DRAIN;
                    end
                end
                // the final sample reaches the statistics stage on the edge v1 has cleared
                if (st == DRAIN && !v1) st <= DONE;
            end
        end
    end

`ifdef APPROX_MON_SQ_EN
    localparam int SW = sq_w(N, CNT_W);
    logic [2*EW-1:0] q2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q2        <= '0;
            sum_sq_ed <= '0;
        end else begin
            q2 <= d1 * d1;
            if (go) sum_sq_ed <= '0;
            else if (v2) sum_sq_ed <= sum_sq_ed + SW'(q2);
        end
    end
`endif
endmodule
